// File: rtl/map_scroll_ctrl.sv
// map_scroll_ctrl: frame-rate scroll scheduler for the side-scrolling map.
// Syncs frame_clk into Clk, advances a wrapping pixel position by the current
// speed once per frame while running, and keeps a saturating run score.
// Build option MAP_SCROLL_RAMP_EN: when defined, speed ramps up by one every
// RAMP_FRAMES running frames (saturating at SPEED_MAX); when undefined, speed
// is the constant SPEED_INIT and RAMP_FRAMES/SPEED_MAX are unused.
//
// state   | meaning
// IDLE    | power-up, counters held at start values, waiting for start
// RUN     | scrolling, one advance per frame tick
// PAUSED  | everything held while pause is high
// OVER    | collision seen, values frozen for display until start
module map_scroll_ctrl #(
  parameter int MAP_BYTES    = 512,
  parameter int SCREEN_BYTES = 80,
  parameter int SPEED_INIT   = 1,
  parameter int SPEED_MAX    = 8,
  parameter int RAMP_FRAMES  = 600
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        start,
  input  logic        pause,
  input  logic        collide,
  output logic [9:0]  shifted_x,
  output logic [2:0]  fine_x,
  output logic [3:0]  speed,
  output logic [1:0]  state,
  output logic [15:0] score
);

  localparam int WRAP_PX = (MAP_BYTES - SCREEN_BYTES) * 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] pos_q, pos_d;
  logic [15:0] score_q, score_d;
  logic        s1_q, s2_q, s3_q;
  logic        tick;
  logic [3:0]  speed_cur;
  logic [12:0] pos_sum;

  assign tick = s2_q & ~s3_q;

`ifdef MAP_SCROLL_RAMP_EN
  localparam int RW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  logic [3:0]    speed_q, speed_d;
  logic [RW-1:0] ramp_q, ramp_d;
  assign speed_cur = speed_q;
`else
  assign speed_cur = 4'(SPEED_INIT);
`endif

  // wrapped position after one advance at the current speed
  always_comb begin
    pos_sum = pos_q + 13'(speed_cur);
    if (pos_sum >= 13'(WRAP_PX)) pos_sum = pos_sum - 13'(WRAP_PX);
  end

  // game-state machine and per-frame advance
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    score_d = score_q;
`ifdef MAP_SCROLL_RAMP_EN
    speed_d = speed_q;
    ramp_d  = ramp_q;
`endif
    case (state_q)
      ST_IDLE, ST_OVER: begin
        // IDLE keeps start values; OVER freezes until start reloads them
        if (state_q == ST_IDLE || start) begin
          pos_d   = '0;
          score_d = '0;
`ifdef MAP_SCROLL_RAMP_EN
          speed_d = 4'(SPEED_INIT);
          ramp_d  = '0;
`endif
        end
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (collide) begin
          state_d = ST_OVER;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (tick) begin
          pos_d = pos_sum;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
`ifdef MAP_SCROLL_RAMP_EN
          if (ramp_q == RW'(RAMP_FRAMES - 1)) begin
            ramp_d = '0;
            if (speed_q < 4'(SPEED_MAX)) speed_d = speed_q + 4'd1;
          end else begin
            ramp_d = ramp_q + RW'(1);
          end
`endif
        end
      end
      ST_PAUSED: begin
        if (collide)     state_d = ST_OVER;
        else if (!pause) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // frame_clk synchronizer plus edge-detect delay flop
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= frame_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // state and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      score_q <= '0;
`ifdef MAP_SCROLL_RAMP_EN
      speed_q <= 4'(SPEED_INIT);
      ramp_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      score_q <= score_d;
`ifdef MAP_SCROLL_RAMP_EN
      speed_q <= speed_d;
      ramp_q  <= ramp_d;
`endif
    end
  end

  assign shifted_x = pos_q[12:3];
  assign fine_x    = pos_q[2:0];
  assign speed     = speed_cur;
  assign state     = state_q;
  assign score     = score_q;

endmodule

// File: tb/tb_map_scroll_ctrl.sv
// Bench for map_scroll_ctrl: vector table on a default instance plus
// sequences for wrap-around, tick latency, collide/tick overlap and async reset.
module tb_map_scroll_ctrl;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_clk = 1'b0;
  logic start_a = 1'b0, pause_a = 1'b0, collide_a = 1'b0;
  logic start_b = 1'b0;
  logic zero_b = 1'b0;

  logic [9:0]  sx_a, sx_b;
  logic [2:0]  fx_a, fx_b;
  logic [3:0]  spd_a, spd_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] sc_a, sc_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 Clk = ~Clk;

  map_scroll_ctrl dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .start(start_a), .pause(pause_a), .collide(collide_a),
    .shifted_x(sx_a), .fine_x(fx_a), .speed(spd_a), .state(st_a), .score(sc_a)
  );

  map_scroll_ctrl #(.SPEED_INIT(5), .RAMP_FRAMES(1000)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .start(start_b), .pause(zero_b), .collide(zero_b),
    .shifted_x(sx_b), .fine_x(fx_b), .speed(spd_b), .state(st_b), .score(sc_b)
  );

`ifdef MAP_SCROLL_RAMP_EN
  logic [9:0]  sx_c;
  logic [2:0]  fx_c;
  logic [3:0]  spd_c;
  logic [1:0]  st_c;
  logic [15:0] sc_c;
  map_scroll_ctrl #(.SPEED_INIT(1), .SPEED_MAX(3), .RAMP_FRAMES(4)) dut_c (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .start(start_b), .pause(zero_b), .collide(zero_b),
    .shifted_x(sx_c), .fine_x(fx_c), .speed(spd_c), .state(st_c), .score(sc_c)
  );
`endif

  typedef struct {
    int kind;   // 0 plain row, 1 latency sequence, 2 collide-with-tick sequence
    int st, pa, co;
    int ticks;
    int e_state, e_pos, e_speed, e_score;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input int e_st, input int e_pos,
                         input int e_spd, input int e_sc);
    check({tag, ".state"}, int'(st_a), e_st);
    check({tag, ".pos"},   int'({sx_a, fx_a}), e_pos);
    check({tag, ".speed"}, int'(spd_a), e_spd);
    check({tag, ".score"}, int'(sc_a), e_sc);
  endtask

  // one frame: rise at a negedge, hold 4 cycles high, 4 cycles low
  task automatic frame();
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 10, 0, 0, 1, 0};
    vecs[1]  = '{0, 1, 0, 0, 0,  1, 0, 1, 0};
    vecs[2]  = '{1, 0, 0, 0, 0,  1, 1, 1, 1};
    vecs[3]  = '{0, 0, 0, 0, 10, 1, 11, 1, 11};
    vecs[4]  = '{0, 0, 0, 0, 9,  1, 20, 1, 20};
    vecs[5]  = '{2, 0, 0, 0, 0,  3, 20, 1, 20};
    vecs[6]  = '{0, 0, 0, 0, 3,  3, 20, 1, 20};
    vecs[7]  = '{0, 1, 0, 0, 0,  1, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 5,  1, 5, 1, 5};
    vecs[9]  = '{0, 0, 1, 0, 5,  2, 5, 1, 5};
    vecs[10] = '{0, 0, 0, 0, 3,  1, 8, 1, 8};
    vecs[11] = '{0, 0, 1, 1, 0,  3, 8, 1, 8};
    vecs[12] = '{0, 1, 0, 0, 0,  1, 0, 1, 0};
    vecs[13] = '{0, 0, 1, 0, 0,  2, 0, 1, 0};
    vecs[14] = '{0, 0, 1, 1, 0,  3, 0, 1, 0};
    vecs[15] = '{0, 1, 0, 0, 0,  1, 0, 1, 0};
    vecs[16] = '{0, 0, 0, 0, 4,  1, 4, 1, 4};

    // reset values while reset is still asserted
    repeat (3) @(negedge Clk);
    check_a("reset", 0, 0, 1, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // wrap-around on dut_b (speed 5); dut_a sits idle with start low
    start_b = 1'b1;
    @(negedge Clk);
    start_b = 1'b0;
    @(negedge Clk);
    for (int i = 1; i <= 692; i++) begin
      frame();
      if (i == 691) begin
        check("wrap.pre.shifted_x", int'(sx_b), 431);
        check("wrap.pre.fine_x",    int'(fx_b), 7);
      end
      if (i == 692) begin
        check("wrap.post.shifted_x", int'(sx_b), 0);
        check("wrap.post.fine_x",    int'(fx_b), 4);
        check("wrap.post.speed",     int'(spd_b), 5);
        check("wrap.post.score",     int'(sc_b), 692);
      end
`ifdef MAP_SCROLL_RAMP_EN
      if (i == 4)  check("ramp.t4",  int'(spd_c), 2);
      if (i == 8)  check("ramp.t8",  int'(spd_c), 3);
      if (i == 12) check("ramp.t12", int'(spd_c), 3);
`endif
    end

    // vector table on dut_a
    for (int r = 0; r < 17; r++) begin
      @(negedge Clk);
      start_a   = vecs[r].st[0];
      pause_a   = vecs[r].pa[0];
      collide_a = vecs[r].co[0];
      if (vecs[r].kind == 1) begin
        frame_clk = 1'b1;
        @(negedge Clk);
        check("lat.e1", int'({sx_a, fx_a}), 0);
        @(negedge Clk);
        check("lat.e2", int'({sx_a, fx_a}), 0);
        @(negedge Clk);
        check("lat.e3", int'({sx_a, fx_a}), 1);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
      end else if (vecs[r].kind == 2) begin
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        collide_a = 1'b1;
        @(negedge Clk);
        collide_a = 1'b0;
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
      end else if (vecs[r].ticks == 0) begin
        @(negedge Clk);
      end else begin
        repeat (vecs[r].ticks) frame();
      end
      check_a($sformatf("row%0d", r), vecs[r].e_state, vecs[r].e_pos,
              vecs[r].e_speed, vecs[r].e_score);
    end

    // asynchronous reset mid-run, checked before any further Clk edge
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check_a("async_rst", 0, 0, 1, 0);
    check("async_rst.b.pos",   int'({sx_b, fx_b}), 0);
    check("async_rst.b.speed", int'(spd_b), 5);
    check("async_rst.b.state", int'(st_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/map_scroll_ctrl.md
# map_scroll_ctrl

Frame-rate scroll scheduler for the side-scrolling map renderer. It turns the ~60 Hz `frame_clk` into a registered pixel scroll position and drives the renderer's byte offset (`shifted_x`), the sub-byte pixel phase, and the current scroll speed. A small game-state machine (idle / run / paused / over) gates scrolling, ramps speed over time, and keeps a run score.

## Interface
- `MAP_BYTES`, 512: map row stride in bytes. Legal range 81..1024.
- `SCREEN_BYTES`, 80: visible width in bytes (640 px).
- `SPEED_INIT`, 1: pixels per frame after start. Legal range 1..15.
- `SPEED_MAX`, 8: speed saturation value. Must be ≥ `SPEED_INIT` and ≤ 15.
- `RAMP_FRAMES`, 600: RUN frames per +1 speed step. Must be ≥ 1.
- `Clk`  in  1  50 MHz system clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `frame_clk`  in  1  frame strobe, asynchronous to `Clk`; the rising edge marks a new frame.
- `start`  in  1  level; sampled in IDLE/OVER.
- `pause`  in  1  level; pauses while high.
- `collide`  in  1  level; collision from the pixel/occupancy logic.
- `shifted_x`  out  10  scroll offset in bytes (`pos[12:3]`).
- `fine_x`  out  3  pixel phase within the byte (`pos[2:0]`).
- `speed`  out  4  current pixels per frame.
- `state`  out  2  IDLE=0, RUN=1, PAUSED=2, OVER=3.
- `score`  out  16  RUN frames elapsed, saturating.

## Operation
- Frame sync: `frame_clk` → 2-flop synchronizer `s1`, `s2` → delay flop `s3`. `tick = s2 & ~s3` is a single-`Clk` pulse per frame.
- Internal `pos` is 13 bits, in pixels. `WRAP_PX = (MAP_BYTES - SCREEN_BYTES) * 8`; 3456 by default.
- **IDLE:** `pos`=0, `speed`=`SPEED_INIT`, ramp counter=0, `score`=0. `start`=1 → RUN.
- **RUN:**
  - Collision: `collide`=1 → OVER, with no position update in that cycle, even if `tick`=1. Collide has priority over pause.
  - Pause: else `pause`=1 → PAUSED, with no update in that cycle.
  - Advance: else, on `tick`: `pos_next = pos + speed`. If `pos_next ≥ WRAP_PX`, then `pos_next -= WRAP_PX`. Also `score += 1`, saturating at 0xFFFF. The ramp step below applies in the same cycle.
- **Ramp:** the ramp counter counts RUN ticks. When it equals `RAMP_FRAMES-1` on a tick, it clears and `speed` increments, saturating at `SPEED_MAX`. The new speed applies from the next tick.
- **PAUSED:** all registers hold. Ticks are ignored. `collide`=1 → OVER. Else `pause`=0 → RUN.
- **OVER:** all values freeze for display. `start`=1 → RUN with IDLE reset values loaded in the same cycle.
- All outputs are registered. `shifted_x`/`fine_x` are direct slices of `pos`; `pos` never exceeds `WRAP_PX-1`.

## Timing
- Reset (async assert, sync release): `state`=IDLE, `pos`=0, `shifted_x`=0, `fine_x`=0, `speed`=`SPEED_INIT`, `score`=0, ramp counter=0, sync flops=0.
- Latency from a `frame_clk` rise meeting setup before `Clk` edge E1:
  - `s1` captures at E1 and `s2` at E2.
  - `tick` is high between E2 and E3.
  - `pos`/`score`/`speed` update at E3.
- State transitions take effect at the `Clk` edge where the condition is sampled. Outputs reflect them in the same edge's register update.
- A tick arriving in the cycle that leaves IDLE or OVER is ignored.
- Reset mid-RUN returns all outputs to their reset values immediately, without waiting for a `Clk` edge.

## Configuration
- `MAP_SCROLL_RAMP_EN` defined: the ramp counter and speed increment are built as described.
- Undefined:
  - No ramp counter is instantiated.
  - `speed` is constant `SPEED_INIT` in all states.
  - `RAMP_FRAMES` and `SPEED_MAX` are unused.

## Test plan
- Reset then release; hold `start`=0 for 10 ticks → `state`=0, `shifted_x`=0, `fine_x`=0, `speed`=1, `score`=0.
- `start` pulse, then 11 `frame_clk` rises at speed 1 → `pos`=11, i.e. `shifted_x`=1, `fine_x`=3, `score`=11. Each update lands 3 `Clk` edges after its rise.
- Wrap-around, ramp undefined, `SPEED_INIT`=5:
  - After 691 ticks → `pos`=3455 (`shifted_x`=431, `fine_x`=7).
  - The next tick → `pos`=4 (`shifted_x`=0, `fine_x`=4).
- Ramp, `RAMP_FRAMES`=4, `SPEED_MAX`=3: after ticks 4, 8, and 12, `speed` reads 2, 3, and 3 (saturated).
- `collide` asserted in the same cycle as `tick` with `pos`=20 → `pos` stays 20 and `state`=3. Later ticks leave all outputs unchanged. Then `start` → `state`=1, `pos`=0, `score`=0.
- `pause` high for 5 ticks in RUN → `state`=2 and `pos` frozen; `pause` low → `state`=1 and advance resumes. `Reset_n` low mid-RUN → all outputs zero/`SPEED_INIT` immediately.
